// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: command, write-data and read-response streams between a host and ram_ctrl
interface ram_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] wdata;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          rdata_ready;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
        input  cmd_ready, wdata_ready, rdata, rdata_valid
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
        output cmd_ready, wdata_ready, rdata, rdata_valid
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst read/write sequencer driving a synchronous RAM, with a buffered read-response FIFO
module ram_ctrl #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int RQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_ctrl_if.slave     bus,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_data_out,
    output logic          busy
);
    localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int OW = $clog2(RQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   beat_q, beat_d;
    logic [AW-1:0] base_q, base_d, last_q, last_d, ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_in_q, ram_data_in_d;
    logic          ram_we_q, ram_we_d, ram_re_q, ram_re_d, re_d_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [DW-1:0] mem_q [RQ_DEPTH];
    logic [DW-1:0] mem_d [RQ_DEPTH];
    logic [OW:0]   fill;
    logic [AW-1:0] cur_addr;
    logic          wr_hs, all_issued, issue, push, pop;

    assign bus.cmd_ready   = state_q == IDLE;
    assign bus.wdata_ready = state_q == WRITE;
    assign bus.rdata_valid = occ_q != '0;
    assign bus.rdata       = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign busy            = state_q != IDLE || ram_re_q || re_d_q;
    assign ram_addr        = ram_addr_q;
    assign ram_data_in     = ram_data_in_q;
    assign ram_we          = ram_we_q;
    assign ram_re          = ram_re_q;

    // beat is one bit wider than the address so a full 2^AW burst can be told apart from "all issued"
    assign cur_addr   = base_q + beat_q[AW-1:0];
    assign wr_hs      = bus.wdata_ready && bus.wdata_valid;
    assign all_issued = beat_q > {1'b0, last_q};
    assign fill       = (OW+1)'(occ_q) + (OW+1)'(ram_re_q) + (OW+1)'(re_d_q);
    assign issue      = state_q == READ && !all_issued && fill < (OW+1)'(RQ_DEPTH);
    assign push       = re_d_q;
    assign pop        = bus.rdata_valid && bus.rdata_ready;

    // Sequencer: next state, beat counter and registered RAM pin values
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        base_d        = base_q;
        last_d        = last_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        ram_re_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d = bus.cmd_write ? WRITE : READ;
                base_d  = bus.cmd_addr;
                last_d  = bus.cmd_len;
                beat_d  = '0;
            end
            WRITE: if (wr_hs) begin
                ram_we_d      = 1'b1;
                ram_addr_d    = cur_addr;
                ram_data_in_d = bus.wdata;
                beat_d        = beat_q + (AW+1)'(1);
                if (beat_q[AW-1:0] == last_q) state_d = IDLE;
            end
            READ: if (issue) begin
                ram_re_d   = 1'b1;
                ram_addr_d = cur_addr;
                beat_d     = beat_q + (AW+1)'(1);
            end else if (all_issued && !ram_re_q && !re_d_q) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response FIFO: push the RAM word one cycle after re, pop on host handshake
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = ram_data_out;
            wr_ptr_d = (wr_ptr_q == PW'(RQ_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PW'(RQ_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        occ_d = occ_q + OW'(push) - OW'(pop);
    end

    // Control and pointer registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            base_q        <= '0;
            last_q        <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            re_d_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            base_q        <= base_d;
            last_q        <= last_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            ram_re_q      <= ram_re_d;
            re_d_q        <= ram_re_q;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // FIFO storage needs no reset: entries are only visible while occ covers them
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The issue rule reserves space for every in-flight read, so a push never meets a full FIFO
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && occ_q == OW'(RQ_DEPTH)));
endmodule
